// File: rtl/tisc_pkg.sv
// Shared definitions for the TISC pipeline: widths, forwarding select codes
// and the control FSM state encoding.
package tisc_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int DATA_W     = 8;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_EX  = 2'b01,
      FWD_MEM = 2'b10,
      FWD_WB  = 2'b11
   } fwd_sel_e;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_MEMWAIT = 2'b01,
      ST_HALTED  = 2'b10,
      ST_ERROR   = 2'b11
   } ctrl_state_e;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one ID/EX source register; the nearest
// producing stage wins, and a load in EX is never a forwarding source.
module fwd_unit
   import tisc_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_reg_write_en,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_reg_write_en,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  wb_reg_write_en,
   output logic [1:0]            sel
);

   always_comb begin
      sel = FWD_RF;
      if (ex_reg_write_en && !ex_mem_read && (ex_rd == rs))
         sel = FWD_EX;
      else if (mem_reg_write_en && (mem_rd == rs))
         sel = FWD_MEM;
      else if (wb_reg_write_en && (wb_rd == rs))
         sel = FWD_WB;
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage TISC pipeline: stage
// enables, bubble/flush controls, forwarding selects, memory wait FSM, halt.
module pipeline_ctrl
   import tisc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [3:0]             id_rs1,
   input  logic [3:0]             id_rs2,
   input  logic                   id_uses_rs1,
   input  logic                   id_uses_rs2,
   input  logic [3:0]             ex_rd,
   input  logic                   ex_reg_write_en,
   input  logic                   ex_mem_read,
   input  logic [3:0]             mem_rd,
   input  logic                   mem_reg_write_en,
   input  logic [3:0]             wb_rd,
   input  logic                   wb_reg_write_en,
   input  logic                   branch_taken,
   input  logic                   mem_req,
   input  logic                   mem_ready,
   input  logic                   halt_i,
   output logic                   pc_en,
   output logic                   ifid_en,
   output logic                   idex_en,
   output logic                   exmem_en,
   output logic                   memwb_en,
   output logic                   ifid_flush,
   output logic                   idex_flush,
   output logic [1:0]             fwd_a,
   output logic [1:0]             fwd_b,
   output logic                   mem_err,
   output logic                   halted,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   ctrl_state_e      state, state_next;
   logic [7:0]       wait_cnt, wait_cnt_next;
   logic             load_use;
   logic [4:0]       en_c;      // {pc, ifid, idex, exmem, memwb}
   logic [1:0]       flush_c;   // {ifid, idex}
   logic [1:0]       fwd_a_c, fwd_b_c;

   assign load_use = ex_mem_read && ex_reg_write_en &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

   // NOTE: every output of this block gets a default before any branch so no
   // path leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      en_c          = '1;
      flush_c       = '0;
      unique case (state)
         ST_RUN: begin
            if (mem_req && !mem_ready) begin
               state_next    = ST_MEMWAIT;
               wait_cnt_next = 8'd1;
            end else if (halt_i) begin
               state_next = ST_HALTED;
            end
         end
         ST_MEMWAIT: begin
            if (mem_ready) begin
               state_next    = halt_i ? ST_HALTED : ST_RUN;
               wait_cnt_next = '0;
            end else begin
               wait_cnt_next = wait_cnt + 8'd1;
               if (wait_cnt_next == TIMEOUT_CNT)
                  state_next = ST_ERROR;
            end
         end
         ST_HALTED, ST_ERROR: ;
         default: state_next = ST_RUN;
      endcase

      // Freeze covers a pending wait, halt and error; the ready cycle of a
      // wait releases the pipeline combinationally.
      if ((state == ST_HALTED) || (state == ST_ERROR) ||
          (mem_req && !mem_ready && (state == ST_RUN)) ||
          ((state == ST_MEMWAIT) && !mem_ready)) begin
         en_c = '0;
      end else if (halt_i) begin
         en_c = '1;
      end else if (branch_taken) begin
         flush_c = 2'b11;
      end else if (load_use) begin
         en_c    = 5'b00111;
         flush_c = 2'b01;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cycles <= '0;
      else if (!pc_en && !halted && (stall_cycles != '1))
         stall_cycles <= stall_cycles + 1'b1;
   end

   fwd_unit u_fwd_a (
      .rs               (id_rs1),
      .ex_rd            (ex_rd),
      .ex_reg_write_en  (ex_reg_write_en),
      .ex_mem_read      (ex_mem_read),
      .mem_rd           (mem_rd),
      .mem_reg_write_en (mem_reg_write_en),
      .wb_rd            (wb_rd),
      .wb_reg_write_en  (wb_reg_write_en),
      .sel              (fwd_a_c)
   );

   fwd_unit u_fwd_b (
      .rs               (id_rs2),
      .ex_rd            (ex_rd),
      .ex_reg_write_en  (ex_reg_write_en),
      .ex_mem_read      (ex_mem_read),
      .mem_rd           (mem_rd),
      .mem_reg_write_en (mem_reg_write_en),
      .wb_rd            (wb_rd),
      .wb_reg_write_en  (wb_reg_write_en),
      .sel              (fwd_b_c)
   );

   // Controls are forced quiet while reset is asserted, independent of clock.
   assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = rst_n ? en_c : 5'b00000;
   assign {ifid_flush, idex_flush} = rst_n ? flush_c : 2'b00;
   assign fwd_a   = rst_n ? fwd_a_c : FWD_RF;
   assign fwd_b   = rst_n ? fwd_b_c : FWD_RF;
   assign halted  = (state == ST_HALTED) || (state == ST_ERROR);
   assign mem_err = (state == ST_ERROR);

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 8-bit, 16-register, five-stage TISC pipeline (IF, ID, EX, MEM, WB).
- Drives the `en` inputs of the PC and of the IFID/IDEX/EXMEM/MEMWB pipeline registers, plus the bubble/flush controls.
- Detects load-use hazards and generates operand-forwarding selects for the ID/EX operands.
- Runs a memory wait-state FSM with timeout, a halt state, and a stall performance counter.

Parameters:
MEM_TIMEOUT, 16, max consecutive wait cycles on a memory access before error (range 2..255)
STALL_CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1  in  4  source register 1 of instruction in ID
id_rs2  in  4  source register 2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  4  destination register of instruction in EX
ex_reg_write_en  in  1  EX instruction writes the register file
ex_mem_read  in  1  EX instruction is a load
mem_rd  in  4  destination register in MEM
mem_reg_write_en  in  1  MEM instruction writes the register file
wb_rd  in  4  destination register in WB
wb_reg_write_en  in  1  WB instruction writes the register file
branch_taken  in  1  EX resolved a taken branch/jump this cycle
mem_req  in  1  MEM-stage instruction accesses data memory
mem_ready  in  1  data memory completes the access this cycle
halt_i  in  1  halt instruction reached WB
pc_en  out  1  PC update enable
ifid_en  out  1  IFID register enable
idex_en  out  1  IDEX register enable
exmem_en  out  1  EXMEM register enable
memwb_en  out  1  MEMWB register enable
ifid_flush  out  1  load NOP into IFID
idex_flush  out  1  load NOP/bubble into IDEX
fwd_a  out  2  rs1 operand source: 00 regfile, 01 EX, 10 MEM, 11 WB
fwd_b  out  2  rs2 operand source, same encoding as fwd_a
mem_err  out  1  sticky memory-timeout error
halted  out  1  core halted
stall_cycles  out  STALL_CNT_W  saturating count of cycles with pc_en=0 while not halted

Behaviour:
- FSM states: RUN, MEMWAIT, HALTED, ERROR.
  - Reset (async, rst_n low): RUN, wait counter 0, stall_cycles 0, mem_err 0, halted 0.
  - While rst_n is low, all enables and flushes are 0 and fwd_a/fwd_b are 00.
- Freeze: all five enables 0, both flushes 0.
- Memory wait:
  - RUN with mem_req=1 and mem_ready=0: freeze this cycle, go to MEMWAIT, wait counter set to 1.
  - RUN with mem_req=1 and mem_ready=1: no stall (zero-wait access).
  - MEMWAIT with mem_ready=1: no freeze this cycle (combinational release); return to RUN; counter cleared.
  - MEMWAIT with mem_ready=0: freeze; counter increments. When the counter reaches MEM_TIMEOUT, go to ERROR.
- ERROR: freeze forever; mem_err=1; halted=1. Only reset exits.
- halt_i=1 in RUN: this cycle completes normally (all enables 1); next state HALTED. HALTED freezes forever; halted=1. Only reset exits.
- Priority when events coincide: memory freeze > halt > branch flush > load-use stall.
- Branch flush (branch_taken=1, no freeze): all enables 1; ifid_flush=1; idex_flush=1. The concurrent load-use hazard is ignored because the ID instruction is being squashed.
- Load-use stall: condition is ex_mem_read AND ex_reg_write_en AND ((id_uses_rs1 AND id_rs1==ex_rd) OR (id_uses_rs2 AND id_rs2==ex_rd)).
  - pc_en=0; ifid_en=0; idex_en=1; idex_flush=1; exmem_en=1; memwb_en=1.
  - Lasts exactly one cycle; the load then sits in MEM and forwarding covers it.
- Forwarding (combinational, evaluated per operand with fwd_b symmetric on rs2):
  - 01 if ex_reg_write_en AND NOT ex_mem_read AND ex_rd==rs.
  - Else 10 if mem_reg_write_en AND mem_rd==rs.
  - Else 11 if wb_reg_write_en AND wb_rd==rs.
  - Else 00.
  - Forwarding does not depend on use bits. All 16 registers are forwardable, including r0.
- stall_cycles: increments on each clock where pc_en=0 and halted=0 and rst_n high. Saturates at all-ones; never wraps.
- Normal RUN with no hazards: all enables 1, flushes 0.

Decomposition:
- Shared package `tisc_pkg`:
  - constants REG_ADDR_W=4, DATA_W=8;
  - fwd select encodings FWD_RF/FWD_EX/FWD_MEM/FWD_WB;
  - ctrl FSM state enum.
- One sub-module `fwd_unit`: purely combinational forwarding select for one operand, instantiated twice.
- Hazard logic and FSM stay in pipeline_ctrl.

Test Plan:
1. Load r3 in EX, ID reads rs1=3 with use bit set -> one cycle of pc_en=0, ifid_en=0, idex_flush=1. Next cycle fwd_a=10 and all enables 1. stall_cycles increments by 1.
2. ex_rd=5 (ALU op), mem_rd=5, wb_rd=5, id_rs2=5 -> fwd_b=01. Remove EX write -> 10. Remove MEM write -> 11. Remove all -> 00.
3. mem_req=1, mem_ready held low 3 cycles then high -> freeze for exactly 3 cycles, release in the ready cycle, FSM returns to RUN.
4. MEM_TIMEOUT=4 with mem_ready never asserted -> ERROR after 4 frozen cycles, mem_err=1 and halted=1 sticky. Asserting mem_ready afterwards changes nothing; rst_n pulse clears everything.
5. branch_taken=1 with simultaneous load-use condition -> ifid_flush=1, idex_flush=1, all enables 1, no stall. Same cycle with mem freeze -> freeze wins, flushes 0.
6. halt_i=1 -> that cycle all enables 1, then halted=1 with enables 0 and stall_cycles frozen. Async rst_n mid-MEMWAIT -> enables drop to 0 immediately, FSM in RUN after release.
